// File: rtl/reg_file_bypass.sv
// Two-write, two-read register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero; optional same-cycle write-to-read forwarding.
module reg_file_bypass #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [AW-1:0]   RS1Sel,
  input  logic [AW-1:0]   RS2Sel,
  output logic [XLEN-1:0] RS1Dat,
  output logic [XLEN-1:0] RS2Dat,
  output logic            RS1Busy,
  output logic            RS2Busy,
  input  logic            WEn0,
  input  logic            WEn1,
  input  logic [AW-1:0]   WSel0,
  input  logic [AW-1:0]   WSel1,
  input  logic [XLEN-1:0] WDat0,
  input  logic [XLEN-1:0] WDat1,
  input  logic            IssueEn,
  input  logic [AW-1:0]   IssueSel
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  logic [AW-1:0]   rsel  [2];
  logic [XLEN-1:0] rdat  [2];
  logic            rbusy [2];

  // Entry 0 is only touched by reset; the read path masks it regardless.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (WEn1 && WSel1 == AW'(i))
          regs[i] <= WDat1;
        else if (WEn0 && WSel0 == AW'(i))
          regs[i] <= WDat0;

        if (IssueEn && IssueSel == AW'(i))
          busy[i] <= 1'b1;
        else if ((WEn0 && WSel0 == AW'(i)) || (WEn1 && WSel1 == AW'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  assign rsel[0] = RS1Sel;
  assign rsel[1] = RS2Sel;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p]  = '0;
      rbusy[p] = 1'b0;
      if (!Rst && rsel[p] != '0) begin
        rdat[p]  = regs[rsel[p]];
        rbusy[p] = busy[rsel[p]];
        // Forwarded data is about to land, so the register no longer waits on a producer.
        if (BYPASS != 0) begin
          if (WEn1 && WSel1 == rsel[p]) begin
            rdat[p]  = WDat1;
            rbusy[p] = 1'b0;
          end else if (WEn0 && WSel0 == rsel[p]) begin
            rdat[p]  = WDat0;
            rbusy[p] = 1'b0;
          end
        end
      end
    end
  end

  assign RS1Dat  = rdat[0];
  assign RS2Dat  = rdat[1];
  assign RS1Busy = rbusy[0];
  assign RS2Busy = rbusy[1];

endmodule

// File: tb/tb_reg_file_bypass.sv
// Bench for reg_file_bypass: directed scenarios plus random traffic against an array model,
// run on a forwarding and a non-forwarding instance driven by the same stimulus.
module tb_reg_file_bypass;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s1, s2, ws0, ws1, isel;
  logic          we0, we1, ie;
  logic [31:0]   wd0, wd1;

  logic [31:0] b_d1, b_d2, n_d1, n_d2;
  logic        b_b1, b_b2, n_b1, n_b2;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mregs [NREGS];
  bit          mbusy [NREGS];

  always #5 clk = ~clk;

  reg_file_bypass #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_b (
    .Clk(clk), .Rst(rst), .RS1Sel(s1), .RS2Sel(s2),
    .RS1Dat(b_d1), .RS2Dat(b_d2), .RS1Busy(b_b1), .RS2Busy(b_b2),
    .WEn0(we0), .WEn1(we1), .WSel0(ws0), .WSel1(ws1), .WDat0(wd0), .WDat1(wd1),
    .IssueEn(ie), .IssueSel(isel)
  );

  reg_file_bypass #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_n (
    .Clk(clk), .Rst(rst), .RS1Sel(s1), .RS2Sel(s2),
    .RS1Dat(n_d1), .RS2Dat(n_d2), .RS1Busy(n_b1), .RS2Busy(n_b2),
    .WEn0(we0), .WEn1(we1), .WSel0(ws0), .WSel1(ws1), .WDat0(wd0), .WDat1(wd1),
    .IssueEn(ie), .IssueSel(isel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  // Value a read port should show given architectural state and this cycle's writes.
  function automatic logic [31:0] exp_dat(input logic [AW-1:0] sel, input bit byp);
    if (rst || sel == 0) return 32'h0;
    if (byp && we1 && ws1 == sel) return wd1;
    if (byp && we0 && ws0 == sel) return wd0;
    return mregs[sel];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [AW-1:0] sel, input bit byp);
    if (rst || sel == 0) return 32'h0;
    if (byp && ((we0 && ws0 == sel) || (we1 && ws1 == sel))) return 32'h0;
    return {31'h0, mbusy[sel]};
  endfunction

  task automatic idle();
    we0 = 0; we1 = 0; ie = 0;
    ws0 = 0; ws1 = 0; isel = 0;
    wd0 = 0; wd1 = 0;
  endtask

  // Settle inputs mid-cycle and compare every output of both instances to the model.
  task automatic probe();
    #4;
    chk("b_rs1_dat",  b_d1, exp_dat(s1, 1));
    chk("b_rs2_dat",  b_d2, exp_dat(s2, 1));
    chk("b_rs1_busy", {31'h0, b_b1}, exp_busy(s1, 1));
    chk("b_rs2_busy", {31'h0, b_b2}, exp_busy(s2, 1));
    chk("n_rs1_dat",  n_d1, exp_dat(s1, 0));
    chk("n_rs2_dat",  n_d2, exp_dat(s2, 0));
    chk("n_rs1_busy", {31'h0, n_b1}, exp_busy(s1, 0));
    chk("n_rs2_busy", {31'h0, n_b2}, exp_busy(s2, 0));
  endtask

  // Clock edge, then apply the same edge to the model: writes in port order so port 1
  // lands last, and issue after write-clear so a new producer keeps the bit set.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mregs[i] = 0;
        mbusy[i] = 0;
      end
    end else begin
      if (we0 && ws0 != 0) begin mregs[ws0] = wd0; mbusy[ws0] = 0; end
      if (we1 && ws1 != 0) begin mregs[ws1] = wd1; mbusy[ws1] = 0; end
      if (ie && isel != 0) mbusy[isel] = 1;
    end
    #1;
  endtask

  task automatic step();
    probe();
    tick();
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      mregs[i] = 0;
      mbusy[i] = 0;
    end
    idle();
    s1 = 0; s2 = 0;
    rst = 1;
    // Reset held with write and issue traffic present: outputs stay zero, state stays clear.
    we0 = 1; ws0 = 6; wd0 = 32'h12345678; ie = 1; isel = 6; s1 = 6; s2 = 6;
    tick();
    probe();
    chk("rst_hold_dat", b_d1, 32'h0);
    chk("rst_hold_busy", {31'h0, b_b2}, 32'h0);
    tick();
    rst = 0;
    idle();

    for (int s = 0; s < NREGS; s++) begin
      s1 = AW'(s);
      s2 = AW'(NREGS - 1 - s);
      probe();
      chk("post_rst_rs1", b_d1 | n_d2, 32'h0);
      chk("post_rst_busy", {30'h0, b_b1, n_b2}, 32'h0);
      tick();
    end

    // Forwarding of a write in its own cycle, then array visibility.
    we0 = 1; ws0 = 2; wd0 = 32'hFFFFFFCF; s1 = 2; s2 = 0;
    probe();
    chk("fwd_byp", b_d1, 32'hFFFFFFCF);
    chk("fwd_nobyp", n_d1, 32'h0);
    tick();
    idle();
    probe();
    chk("after_wr_byp", b_d1, 32'hFFFFFFCF);
    chk("after_wr_nobyp", n_d1, 32'hFFFFFFCF);
    tick();

    // Same-register collision: port 1 wins.
    we0 = 1; ws0 = 5; wd0 = 32'h11111111;
    we1 = 1; ws1 = 5; wd1 = 32'h22222222; s1 = 5; s2 = 5;
    probe();
    chk("collide_fwd", b_d2, 32'h22222222);
    tick();
    idle();
    probe();
    chk("collide_arr", n_d1, 32'h22222222);
    tick();

    // Register 0 ignores writes and issue.
    we0 = 1; ws0 = 0; wd0 = 32'hFFFCFFFC; ie = 1; isel = 0; s1 = 0;
    probe();
    chk("r0_dat_wr", b_d1, 32'h0);
    tick();
    idle();
    probe();
    chk("r0_dat", b_d1, 32'h0);
    chk("r0_busy", {31'h0, b_b1}, 32'h0);
    tick();

    // Scoreboard life cycle on r7.
    ie = 1; isel = 7; s2 = 7;
    step();
    idle();
    probe();
    chk("r7_busy", {31'h0, b_b2}, 32'h1);
    tick();
    we0 = 1; ws0 = 7; wd0 = 32'h0000ABCD;
    probe();
    chk("r7_busy_fwd", {31'h0, b_b2}, 32'h0);
    chk("r7_busy_nofwd", {31'h0, n_b2}, 32'h1);
    chk("r7_dat_fwd", b_d2, 32'h0000ABCD);
    tick();
    idle();
    probe();
    chk("r7_busy_clr", {31'h0, n_b2}, 32'h0);
    tick();
    ie = 1; isel = 7; we1 = 1; ws1 = 7; wd1 = 32'h00000777;
    step();
    idle();
    ie = 1; isel = 7;
    probe();
    chk("r7_reissue", {31'h0, n_b2}, 32'h1);
    tick();
    idle();
    probe();
    chk("r7_still_busy", {31'h0, b_b2}, 32'h1);
    tick();

    // Reset mid-sequence wipes data and scoreboard.
    we0 = 1; ws0 = 3; wd0 = 32'hDEADBEEF;
    step();
    idle();
    ie = 1; isel = 4; s1 = 4; s2 = 3;
    step();
    idle();
    probe();
    chk("r4_busy_pre", {31'h0, b_b1}, 32'h1);
    chk("r3_pre", b_d2, 32'hDEADBEEF);
    tick();
    rst = 1; we1 = 1; ws1 = 3; wd1 = 32'h55555555; ie = 1; isel = 9;
    step();
    rst = 0;
    idle();
    we0 = 1; ws0 = 9; wd0 = 32'hCAFEF00D;
    probe();
    chk("r3_after_rst", n_d2, 32'h0);
    chk("r4_busy_after_rst", {31'h0, b_b1}, 32'h0);
    tick();
    idle();
    s1 = 9;
    probe();
    chk("first_wr_after_rst", n_d1, 32'hCAFEF00D);
    tick();

    // Random traffic with selects biased to a few registers to force collisions.
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 59) == 0);
      we0  = $urandom_range(0, 1) == 1;
      we1  = $urandom_range(0, 2) == 0;
      ie   = $urandom_range(0, 1) == 1;
      ws0  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ws1  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      isel = AW'($urandom_range(0, 7));
      s1   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      s2   = ($urandom_range(0, 4) == 0) ? s1 : AW'($urandom_range(0, 7));
      wd0  = $urandom;
      wd1  = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_bypass.md
REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

Interface
REQ-001 Parameter XLEN, default 32, data width of every register and data port.
REQ-002 Parameter NREGS, default 32, number of architectural registers; power of two, >= 2.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled, 0 = disabled.
REQ-004 Derived AW = log2(NREGS), register select width.
REQ-005 Clk  input  1  single clock; all state updates on rising edge.
REQ-006 Rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-007 RS1Sel, RS2Sel  input  AW  read port select.
REQ-008 RS1Dat, RS2Dat  output  XLEN  read port data, combinational.
REQ-009 RS1Busy, RS2Busy  output  1  scoreboard busy flag for the selected register, combinational.
REQ-010 WEn0, WEn1  input  1  write enable, ports 0 and 1.
REQ-011 WSel0, WSel1  input  AW  write register select.
REQ-012 WDat0, WDat1  input  XLEN  write data.
REQ-013 IssueEn  input  1  marks register IssueSel as pending writeback.
REQ-014 IssueSel  input  AW  register to mark busy.

Function
REQ-015 Register 0 SHALL read as zero, never be written, and never report busy.
REQ-016 On a rising edge with WEnN=1 and WSelN!=0, register WSelN SHALL take WDatN; visible via array path from the next cycle.
REQ-017 Both ports enabled to the same nonzero register in one cycle: port 1 SHALL win; port 0 data discarded.
REQ-018 Different registers written in one cycle SHALL both update.
REQ-019 With BYPASS=1, RSxDat SHALL return the current-cycle write data when an enabled write port targets RSxSel!=0 (port 1 priority per REQ-017); otherwise array contents.
REQ-020 With BYPASS=0, RSxDat SHALL return array contents only (old value in the write cycle).
REQ-021 Scoreboard: one busy bit per register; set on edge when IssueEn=1 and IssueSel!=0.
REQ-022 Busy bit SHALL clear on the edge at which any enabled write port targets that register.
REQ-023 Issue and write to the same register in one cycle: busy SHALL end set (new producer wins).
REQ-024 RSxBusy = busy[RSxSel], except with BYPASS=1 it SHALL read 0 when an enabled write targets RSxSel this cycle.
REQ-025 Issue to an already-busy register SHALL leave it busy; no error flag.
REQ-026 Both read ports SHALL be fully independent; RS1Sel=RS2Sel returns identical data and busy.

Reset
REQ-027 Rst=1 at a rising edge SHALL zero all registers and clear all busy bits, overriding writes and issue in that cycle.
REQ-028 While Rst=1, RS1Dat, RS2Dat SHALL be 0 and RS1Busy, RS2Busy SHALL be 0; bypass suppressed.
REQ-029 Reset asserted mid-sequence (register busy, write pending) SHALL leave the array all-zero and no register busy after the edge.
REQ-030 First write after Rst falls SHALL be accepted in the first cycle with Rst=0.

Verification
REQ-031 Reset, then read all registers on both ports -> every RSxDat=0, every RSxBusy=0.
REQ-032 WEn0=1, WSel0=2, WDat0=FFFFFFCF, RS1Sel=2 same cycle -> RS1Dat=FFFFFFCF (BYPASS=1) / 00000000 (BYPASS=0); next cycle FFFFFFCF both modes.
REQ-033 WEn0=1 WSel0=5 WDat0=11111111 and WEn1=1 WSel1=5 WDat1=22222222 -> register 5 reads 22222222.
REQ-034 WSel0=0, WDat0=FFFCFFFC, WEn0=1; IssueSel=0, IssueEn=1 -> RS1Sel=0 reads 0, RS1Busy=0.
REQ-035 Issue r7 -> RS2Busy=1 next cycle; write r7=0000ABCD -> RS2Busy=0 same cycle (BYPASS=1), busy clear next; issue+write r7 same cycle -> busy=1 after edge.
REQ-036 Write r3=DEADBEEF, issue r4, then Rst=1 one cycle -> r3 reads 0, RS1Busy for r4 = 0.
